wb_commit_stage: RTL

Registered writeback/commit stage for the NPC core, following the single-cycle writeback logic. Accepts one executed instruction per handshake and waits for the load response when needed. Aligns and sign/zero-extends load data for sub-word and XLEN=64 loads. Issues exactly one register-file write, branch/jump redirect and retire pulse per instruction.

---
 rtl/wb_commit_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: registered writeback/commit stage; waits for load data, then issues
// one register write, redirect and retire pulse per instruction.
module wb_commit_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_csr_rdata,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_func3,
    input  logic [RF_AW-1:0] in_rd,
    input  logic             in_alu_zero,
    input  logic             in_alu_less,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_wen,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             retire_valid,
    output logic [XLEN-1:0]  retire_pc,
    output logic             busy
);
    localparam int OFFW = $clog2(XLEN / 8);
    localparam int SAW  = OFFW + 3;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0]  pc_q, imm_q, rs1_q, alu_q, csr_q, ld_q;
    logic [6:0]       op_q;
    logic [2:0]       f3_q;
    logic [RF_AW-1:0] rd_q, waddr_q;
    logic             zero_q, less_q;
    logic [XLEN-1:0]  wdata_q, rpc_q, retpc_q;
    logic             accept, commit;
    logic [SAW-1:0]   sa;
    logic [7:0]       lb;
    logic [15:0]      lh;
    logic [31:0]      lw;
    logic [XLEN-1:0]  ld_ext, wdata_c, rpc_c;
    logic             taken, writes, redir_c;

    assign in_ready = state != WAIT_MEM;
    assign accept   = in_valid && in_ready;
    assign commit   = state == COMMIT;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        if (state == WAIT_MEM) state_nx = mem_rvalid ? COMMIT : WAIT_MEM;
        else if (accept) state_nx = (in_opcode == OP_LOAD) ? WAIT_MEM : COMMIT;
    end

    // Lane selection: halfword/word offsets are forced aligned by masking the shift amount.
    assign sa = {alu_q[OFFW-1:0], 3'b000};
    assign lb = 8'(mem_rdata >> sa);
    assign lh = 16'(mem_rdata >> (sa & ~SAW'(15)));
    assign lw = 32'(mem_rdata >> (sa & ~SAW'(31)));

    // With XLEN=32, lw equals mem_rdata, so LWU and LD fall back to plain LW data.
    always_comb begin
        ld_ext = '0;
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(lb));
            3'b100:  ld_ext = XLEN'(lb);
            3'b001:  ld_ext = XLEN'($signed(lh));
            3'b101:  ld_ext = XLEN'(lh);
            3'b010:  ld_ext = XLEN'($signed(lw));
            3'b110:  ld_ext = XLEN'(lw);
            3'b011:  ld_ext = mem_rdata;
            default: ld_ext = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3_q)
            3'b000:         taken = zero_q;
            3'b001:         taken = !zero_q;
            3'b100, 3'b110: taken = less_q;
            3'b101, 3'b111: taken = !less_q;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        wdata_c = '0;
        writes  = 1'b1;
        case (op_q)
            OP_LUI:          wdata_c = imm_q;
            OP_AUIPC:        wdata_c = pc_q + imm_q;
            OP_JAL, OP_JALR: wdata_c = pc_q + XLEN'(4);
            OP_LOAD:         wdata_c = ld_q;
            OP_CSR:          wdata_c = csr_q;
            OP_I, OP_R:      wdata_c = alu_q;
            default:         writes  = 1'b0;
        endcase
    end

    assign redir_c = (op_q == OP_JAL) || (op_q == OP_JALR && f3_q == 3'b000) || (op_q == OP_B && taken);
    assign rpc_c   = (op_q == OP_JALR) ? ((rs1_q + imm_q) & ~XLEN'(1)) : pc_q + imm_q;

    assign rf_wen         = commit && writes && rd_q != '0;
    assign rf_waddr       = commit ? rd_q : waddr_q;
    assign rf_wdata       = commit ? wdata_c : wdata_q;
    assign redirect_valid = commit && redir_c;
    assign redirect_pc    = commit ? rpc_c : rpc_q;
    assign retire_valid   = commit;
    assign retire_pc      = commit ? pc_q : retpc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            alu_q   <= '0;
            csr_q   <= '0;
            ld_q    <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            zero_q  <= 1'b0;
            less_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rpc_q   <= '0;
            retpc_q <= '0;
        end else begin
            if (accept) begin
                pc_q   <= in_pc;
                imm_q  <= in_imm;
                rs1_q  <= in_rs1_val;
                alu_q  <= in_alu_result;
                csr_q  <= in_csr_rdata;
                op_q   <= in_opcode;
                f3_q   <= in_func3;
                rd_q   <= in_rd;
                zero_q <= in_alu_zero;
                less_q <= in_alu_less;
            end
            if (state == WAIT_MEM && mem_rvalid) ld_q <= ld_ext;
            if (commit) begin
                waddr_q <= rd_q;
                wdata_q <= wdata_c;
                rpc_q   <= rpc_c;
                retpc_q <= pc_q;
            end
        end
    end
endmodule
